// File: rtl/wbslv_pkg.sv
// rtl/wbslv_pkg.sv - register map constants, reset values and FSM encoding for wbslv_regs
package wbslv_pkg;

    localparam logic [7:0] ADR_CTRL    = 8'h00;
    localparam logic [7:0] ADR_SCRATCH = 8'h01;
    localparam logic [7:0] ADR_PULSE   = 8'h02;
    localparam logic [7:0] ADR_STATUS  = 8'h03;
    localparam logic [7:0] ADR_EVTCNT  = 8'h04;
    localparam logic [7:0] ADR_ID      = 8'h05;

    localparam logic [15:0] RST_CTRL    = 16'h0000;
    localparam logic [15:0] RST_SCRATCH = 16'hA5A5;
    localparam logic [15:0] RD_UNMAPPED = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wbslv_evtcnt.sv
// rtl/wbslv_evtcnt.sv - saturating 16-bit event counter; clear has priority over increment
module wbslv_evtcnt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        clr_i,
    output logic [15:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_o <= 16'h0000;
        end else if (clr_i) begin
            cnt_o <= 16'h0000;
        end else if (inc_i && (cnt_o != 16'hFFFF)) begin
            cnt_o <= cnt_o + 16'd1;
        end
    end

endmodule

// File: rtl/wbslv_regs.sv
// rtl/wbslv_regs.sv - Wishbone slave register block with programmable wait states
module wbslv_regs #(
    parameter logic [3:0]  MOD_ID   = 4'h1,
    parameter int          WAIT_CYC = 0,
    parameter logic [15:0] HW_ID    = 16'h0A11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] adr_i,
    input  logic [15:0] dat_i,
    output logic [15:0] dat_o,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic [15:0] ctrl_o,
    output logic [15:0] pulse_o,
    input  logic [15:0] sts_i,
    input  logic        evt_i
);
    import wbslv_pkg::*;

    localparam logic [3:0] WAIT_N = 4'(WAIT_CYC);

    wb_state_e   state, state_nxt;
    logic [3:0]  wait_cnt;
    logic        sel, commit, wr_commit;
    logic [7:0]  reg_q, reg_c;
    logic [15:0] wdat_q, wdat_c;
    logic        we_q, we_c;
    logic [15:0] ctrl_q, scratch_q, sts_q, evt_cnt, rd_mux, dat_q, pulse_q;

    assign sel = cyc_i & stb_i & (adr_i[11:8] == MOD_ID);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (sel) state_nxt = (WAIT_N == 4'd0) ? ST_ACK : ST_WAIT;
            ST_WAIT: begin
                if (!(cyc_i && stb_i)) begin
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == WAIT_N) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_o  = (state == ST_ACK);
        commit = (state_nxt == ST_ACK);
    end

    // wait_cnt counts cycles already spent in WAIT, including the current one
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= 4'd0;
        end else if (state_nxt == ST_WAIT) begin
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 4'd1 : 4'd1;
        end else begin
            wait_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            reg_q  <= 8'h00;
            wdat_q <= 16'h0000;
            we_q   <= 1'b0;
        end else if ((state == ST_IDLE) && sel) begin
            reg_q  <= adr_i[7:0];
            wdat_q <= dat_i;
            we_q   <= we_i;
        end
    end

    // With no wait states the commit edge is the selection edge, so use live bus values
    assign reg_c     = (state == ST_IDLE) ? adr_i[7:0] : reg_q;
    assign wdat_c    = (state == ST_IDLE) ? dat_i      : wdat_q;
    assign we_c      = (state == ST_IDLE) ? we_i       : we_q;
    assign wr_commit = commit & we_c;

    always_comb begin
        rd_mux = RD_UNMAPPED;
        case (reg_c)
            ADR_CTRL:    rd_mux = ctrl_q;
            ADR_SCRATCH: rd_mux = scratch_q;
            ADR_PULSE:   rd_mux = 16'h0000;
            ADR_STATUS:  rd_mux = sts_q;
            ADR_EVTCNT:  rd_mux = evt_cnt;
            ADR_ID:      rd_mux = HW_ID;
            default:     rd_mux = RD_UNMAPPED;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q    <= RST_CTRL;
            scratch_q <= RST_SCRATCH;
            sts_q     <= 16'h0000;
            pulse_q   <= 16'h0000;
            dat_q     <= 16'h0000;
        end else begin
            sts_q   <= sts_i;
            pulse_q <= (wr_commit && (reg_c == ADR_PULSE)) ? wdat_c : 16'h0000;
            dat_q   <= (commit && !we_c) ? rd_mux : 16'h0000;
            if (wr_commit && (reg_c == ADR_CTRL)) ctrl_q <= wdat_c;
            if (wr_commit && (reg_c == ADR_SCRATCH)) scratch_q <= wdat_c;
        end
    end

    wbslv_evtcnt u_evtcnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (evt_i),
        .clr_i (wr_commit && (reg_c == ADR_EVTCNT)),
        .cnt_o (evt_cnt)
    );

    assign ctrl_o  = ctrl_q;
    assign pulse_o = pulse_q;
    assign dat_o   = dat_q;

endmodule

// File: tb/tb_wbslv_regs.sv
// tb/tb_wbslv_regs.sv - randomized bench for wbslv_regs, two instances (0 and 3 wait states)
module tb_wbslv_regs;

    typedef struct {
        int          d;
        int          cyc;
        bit          we;
        logic [7:0]  adr;
        logic [15:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] adr;
    logic [15:0] dat;
    logic        we, stb;
    logic [1:0]  cyc;
    logic [15:0] sts = 16'h0000;
    logic        evt = 1'b0;
    logic [1:0]  ack;
    logic [15:0] dat_o [2];
    logic [15:0] ctrl_o [2];
    logic [15:0] pulse_o [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int evt_mode = 2;

    exp_t        expq[$];
    exp_t        ce;
    bit [1:0]    ea;
    logic [15:0] rdv_m;
    logic [15:0] m_ctrl [2];
    logic [15:0] m_scr [2];
    int          m_evt [2];
    logic [15:0] m_sts;
    logic        prev_evt = 1'b0;
    logic [15:0] prev_sts = 16'h0000;
    logic        prev_rst = 1'b0;

    always #5 clk = ~clk;

    wbslv_regs #(.MOD_ID(4'h1), .WAIT_CYC(0), .HW_ID(16'h0A11)) u_dut0 (
        .clk_i(clk), .rst_i(rst_n), .adr_i(adr), .dat_i(dat), .dat_o(dat_o[0]),
        .we_i(we), .stb_i(stb), .cyc_i(cyc[0]), .ack_o(ack[0]), .ctrl_o(ctrl_o[0]),
        .pulse_o(pulse_o[0]), .sts_i(sts), .evt_i(evt)
    );

    wbslv_regs #(.MOD_ID(4'h2), .WAIT_CYC(3), .HW_ID(16'h0B22)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .adr_i(adr), .dat_i(dat), .dat_o(dat_o[1]),
        .we_i(we), .stb_i(stb), .cyc_i(cyc[1]), .ack_o(ack[1]), .ctrl_o(ctrl_o[1]),
        .pulse_o(pulse_o[1]), .sts_i(sts), .evt_i(evt)
    );

    function automatic int wcyc(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [3:0] modid(input int d);
        return (d == 0) ? 4'h1 : 4'h2;
    endfunction

    function automatic logic [15:0] hwid(input int d);
        return (d == 0) ? 16'h0A11 : 16'h0B22;
    endfunction

    function automatic logic [15:0] mread(input int d, input logic [7:0] a);
        case (a)
            8'h00:   return m_ctrl[d];
            8'h01:   return m_scr[d];
            8'h02:   return 16'h0000;
            8'h03:   return m_sts;
            8'h04:   return 16'(m_evt[d]);
            8'h05:   return hwid(d);
            default: return 16'hDEAD;
        endcase
    endfunction

    task automatic chk(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got %h, want %h", nm, d, cyc_n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(posedge clk) begin
        #2;
        case (evt_mode)
            0:       evt = 1'($urandom % 2);
            1:       evt = 1'b1;
            default: evt = 1'b0;
        endcase
        sts = 16'($urandom);
    end

    // Reference model: each negedge, reads use state as it stood before the latest edge,
    // then state advances by one edge using the inputs of the previous cycle.
    always @(negedge clk) begin
        ea = 2'b00;
        rdv_m = 16'h0000;
        if (expq.size() > 0 && expq[0].cyc == cyc_n) begin
            ce = expq.pop_front();
            ea[ce.d] = 1'b1;
            rdv_m = mread(ce.d, ce.adr);
        end
        if (!rst_n || !prev_rst) begin
            m_ctrl = '{16'h0000, 16'h0000};
            m_scr  = '{16'hA5A5, 16'hA5A5};
            m_evt  = '{0, 0};
            m_sts  = 16'h0000;
        end else begin
            m_sts = prev_sts;
            for (int d = 0; d < 2; d++) begin
                if (ea[d] && ce.we && ce.adr == 8'h04) m_evt[d] = 0;
                else if (prev_evt) m_evt[d] = (m_evt[d] + 1 > 65535) ? 65535 : m_evt[d] + 1;
            end
            if (ea != 2'b00 && ce.we) begin
                if (ce.adr == 8'h00) m_ctrl[ce.d] = ce.dat;
                if (ce.adr == 8'h01) m_scr[ce.d] = ce.dat;
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk("ack", d, 16'(ack[d]), 16'(ea[d]));
            chk("pulse", d, pulse_o[d], (ea[d] && ce.we && ce.adr == 8'h02) ? ce.dat : 16'h0000);
            chk("ctrl", d, ctrl_o[d], m_ctrl[d]);
            if (!(ea[d] && ce.we)) chk("dat", d, dat_o[d], ea[d] ? rdv_m : 16'h0000);
        end
        prev_evt = evt;
        prev_sts = sts;
        prev_rst = rst_n;
    end

    task automatic wb_txn(input int d, input bit w, input logic [11:0] a, input logic [15:0] v,
                          input int abort_k, input int nhold,
                          output logic [15:0] rd, output logic [15:0] pls,
                          output int nack, output int lat);
        int  wc, t0, ncy;
        bit  sel;
        wc  = wcyc(d);
        sel = (a[11:8] == modid(d));
        rd = 16'h0000; pls = 16'h0000; nack = 0; lat = -1;
        tick();
        t0 = cyc_n;
        adr = a; dat = v; we = w; stb = 1'b1; cyc[d] = 1'b1;
        if (!sel) ncy = nhold;
        else if (abort_k > 0) ncy = abort_k;
        else begin
            ncy = wc + 2;
            expq.push_back('{d, t0 + wc + 1, w, a[7:0], v});
        end
        for (int i = 0; i < ncy; i++) begin
            @(negedge clk);
            if (ack[d]) begin
                nack++;
                rd = dat_o[d];
                pls = pulse_o[d];
                if (lat < 0) lat = i;
            end
            tick();
        end
        stb = 1'b0; cyc[d] = 1'b0; we = 1'b0;
    endtask

    task automatic wb_hold_read(input int d, input logic [11:0] a, input int n, output int nack);
        int wc, t0;
        wc = wcyc(d);
        nack = 0;
        tick();
        t0 = cyc_n;
        adr = a; we = 1'b0; stb = 1'b1; cyc[d] = 1'b1;
        for (int k = 0; k < n; k++) expq.push_back('{d, t0 + k * (wc + 2) + wc + 1, 1'b0, a[7:0], 16'h0000});
        for (int i = 0; i < n * (wc + 2); i++) begin
            @(negedge clk);
            if (ack[d]) nack++;
            tick();
        end
        stb = 1'b0; cyc[d] = 1'b0;
    endtask

    initial begin
        logic [15:0] rd, pls;
        int          nack, lat, d, r, k;
        bit          w;
        logic [3:0]  m;

        rst_n = 1'b0; cyc = 2'b00; stb = 1'b0; we = 1'b0; adr = 12'h000; dat = 16'h0000;
        @(negedge clk);
        chk("rst_ack", 0, 16'(ack), 16'h0000);
        chk("rst_ctrl", 1, ctrl_o[1], 16'h0000);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        wb_txn(0, 1'b1, 12'h100, 16'hFFFF, 0, 0, rd, pls, nack, lat);
        wb_txn(0, 1'b0, 12'h100, 16'h0000, 0, 0, rd, pls, nack, lat);
        chk("ctrl_rd", 0, rd, 16'hFFFF);
        chk("ctrl_lat", 0, 16'(lat), 16'd1);
        chk("ctrl_o", 0, ctrl_o[0], 16'hFFFF);

        wb_txn(0, 1'b0, 12'h10E, 16'h0000, 0, 0, rd, pls, nack, lat);
        chk("unmapped_rd", 0, rd, 16'hDEAD);
        wb_txn(0, 1'b1, 12'h205, 16'h4321, 0, 20, rd, pls, nack, lat);
        chk("modid_noack", 0, 16'(nack), 16'd0);

        wb_txn(0, 1'b1, 12'h102, 16'h0081, 0, 0, rd, pls, nack, lat);
        chk("pulse_val", 0, pls, 16'h0081);
        wb_txn(0, 1'b0, 12'h102, 16'h0000, 0, 0, rd, pls, nack, lat);
        chk("pulse_rd", 0, rd, 16'h0000);

        wb_txn(0, 1'b0, 12'h105, 16'h0000, 0, 0, rd, pls, nack, lat);
        chk("id0", 0, rd, 16'h0A11);
        wb_txn(1, 1'b0, 12'h205, 16'h0000, 0, 0, rd, pls, nack, lat);
        chk("id1", 1, rd, 16'h0B22);

        wb_txn(1, 1'b1, 12'h201, 16'h1234, 2, 0, rd, pls, nack, lat);
        chk("abort_noack", 1, 16'(nack), 16'd0);
        wb_txn(1, 1'b0, 12'h201, 16'h0000, 0, 0, rd, pls, nack, lat);
        chk("abort_scratch", 1, rd, 16'hA5A5);
        wb_txn(1, 1'b1, 12'h201, 16'h1234, 0, 0, rd, pls, nack, lat);
        chk("wait_lat", 1, 16'(lat), 16'd4);
        wb_txn(1, 1'b0, 12'h201, 16'h0000, 0, 0, rd, pls, nack, lat);
        chk("scratch_rd", 1, rd, 16'h1234);

        wb_hold_read(0, 12'h101, 3, nack);
        chk("held_acks0", 0, 16'(nack), 16'd3);
        wb_hold_read(1, 12'h201, 2, nack);
        chk("held_acks1", 1, 16'(nack), 16'd2);

        evt_mode = 0;
        for (int i = 0; i < 300; i++) begin
            d = int'($urandom % 2);
            w = 1'($urandom % 2);
            r = int'($urandom % 8);
            m = ($urandom % 10 == 0) ? (modid(d) ^ 4'h4) : modid(d);
            k = (d == 1 && $urandom % 5 == 0) ? int'($urandom_range(1, 3)) : 0;
            wb_txn(d, w, {m, 8'(r)}, 16'($urandom), k, 4, rd, pls, nack, lat);
            repeat ($urandom % 3) tick();
        end

        evt_mode = 1;
        repeat (65600) tick();
        wb_txn(0, 1'b0, 12'h104, 16'h0000, 0, 0, rd, pls, nack, lat);
        chk("evt_sat0", 0, rd, 16'hFFFF);
        wb_txn(0, 1'b1, 12'h104, 16'h0000, 0, 0, rd, pls, nack, lat);
        evt_mode = 2;
        wb_txn(0, 1'b0, 12'h104, 16'h0000, 0, 0, rd, pls, nack, lat);
        chk("evt_clr", 0, rd, 16'h0001);
        wb_txn(1, 1'b0, 12'h204, 16'h0000, 0, 0, rd, pls, nack, lat);
        chk("evt_sat1", 1, rd, 16'hFFFF);

        wb_txn(1, 1'b1, 12'h200, 16'h5A5A, 0, 0, rd, pls, nack, lat);
        tick();
        adr = 12'h201; dat = 16'h1234; we = 1'b1; stb = 1'b1; cyc[1] = 1'b1;
        repeat (2) tick();
        rst_n = 1'b0;
        expq.delete();
        stb = 1'b0; cyc = 2'b00; we = 1'b0;
        @(negedge clk);
        chk("rst_wait_ack", 1, 16'(ack[1]), 16'h0000);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ctrl1", 1, ctrl_o[1], 16'h0000);
        chk("rst_ctrl0", 0, ctrl_o[0], 16'h0000);
        wb_txn(1, 1'b0, 12'h201, 16'h0000, 0, 0, rd, pls, nack, lat);
        chk("rst_scratch", 1, rd, 16'hA5A5);
        chk("rst_fresh_lat", 1, 16'(lat), 16'd4);
        wb_txn(0, 1'b0, 12'h104, 16'h0000, 0, 0, rd, pls, nack, lat);
        chk("rst_evt", 0, rd, 16'h0000);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wbslv_regs.md
WBSLV_REGS -- requirements
Module: wbslv_regs

Interface
REQ-001 SHALL have parameter MOD_ID, default 4'h1: module field matched against adr_i[11:8].
REQ-002 SHALL have parameter WAIT_CYC, default 0: wait states inserted before ack, range 0..15.
REQ-003 SHALL have parameter HW_ID, default 16'h0A11: constant returned by the ID register.
REQ-004 clk_i  input  1  single clock; all logic rising-edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-low.
REQ-006 adr_i  input  12  Wishbone address, {module[3:0], register[7:0]}.
REQ-007 dat_i  input  16  Wishbone write data.
REQ-008 dat_o  output  16  Wishbone read data.
REQ-009 we_i  input  1  1 = write, 0 = read.
REQ-010 stb_i, cyc_i  input  1 each  Wishbone strobe and cycle.
REQ-011 ack_o  output  1  Wishbone acknowledge.
REQ-012 ctrl_o  output  16  CTRL register contents.
REQ-013 pulse_o  output  16  one-cycle write-one pulses.
REQ-014 sts_i  input  16  status inputs, read-only.
REQ-015 evt_i  input  1  event to be counted.

Function
REQ-016 Selection SHALL be cyc_i & stb_i & (adr_i[11:8] == MOD_ID); unselected cycles produce no ack and no register change.
REQ-017 FSM states SHALL be IDLE, WAIT, ACK.
- IDLE->WAIT on selection when WAIT_CYC > 0.
- IDLE->ACK on selection when WAIT_CYC = 0.
- WAIT->ACK after WAIT_CYC cycles in WAIT.
- ACK->IDLE always.
REQ-018 ack_o SHALL be registered, high for exactly one cycle (ACK state); latency from first selected cycle to ack_o = WAIT_CYC+1 cycles.
REQ-019 After ACK the FSM SHALL return to IDLE for at least one cycle, so a held strobe gives ack every WAIT_CYC+2 cycles.
REQ-020 If cyc_i or stb_i drops while in WAIT, the FSM SHALL return to IDLE with no ack, no write, and no pulse.
REQ-021 Address and data SHALL be sampled in the selection cycle, and the write SHALL commit on the clock edge that enters ACK.
REQ-022 Register map (adr_i[7:0]):
- 0x00 CTRL: RW, reset 0x0000.
- 0x01 SCRATCH: RW, reset 0xA5A5.
- 0x02 PULSE: write-one pulses, reads 0x0000.
- 0x03 STATUS: RO, returns sts_i registered one cycle.
- 0x04 EVTCNT: RO counter; any write clears it.
- 0x05 ID: RO, returns HW_ID.
REQ-023 Writes to RO registers and unmapped addresses SHALL be ignored but acked; reads of unmapped addresses SHALL return 0xDEAD.
REQ-024 pulse_o SHALL equal the written data for exactly the ACK cycle and 0x0000 otherwise.
REQ-025 EVTCNT SHALL increment by 1 in each cycle with evt_i=1 and saturate at 0xFFFF without wrapping.
REQ-026 When an EVTCNT write and evt_i=1 occur in the same cycle, the clear SHALL win (result 0x0000).
REQ-027 dat_o SHALL be registered, valid only while ack_o=1, and 0x0000 otherwise.

Reset
REQ-028 While rst_i=0: FSM=IDLE, ack_o=0, dat_o=0x0000, ctrl_o=0x0000, SCRATCH=0xA5A5, pulse_o=0x0000, EVTCNT=0, STATUS sample=0.
REQ-029 Reset asserted mid-cycle SHALL abort the transaction with no ack, and the first selection after release SHALL start a fresh cycle.

Structure
REQ-030 Package wbslv_pkg SHALL hold the register address constants, reset values, the 0xDEAD default, and the FSM state encoding.
REQ-031 The saturating counter SHALL be sub-module wbslv_evtcnt (ports: clk_i, rst_i, inc_i, clr_i, cnt_o[15:0]).

Verification
REQ-032 Write 0xFFFF to adr 0x100, then read adr 0x100 -> read ack after 1 cycle, dat_o=0xFFFF, ctrl_o=0xFFFF.
REQ-033 Read adr 0x10E (unmapped) -> ack, dat_o=0xDEAD; write to adr 0x205 (MOD_ID mismatch) -> no ack for 20 cycles.
REQ-034 Write 0x0081 to adr 0x102 -> pulse_o=0x0081 for exactly one cycle; a read of 0x102 returns 0x0000.
REQ-035 Hold evt_i=1 for 70000 cycles -> EVTCNT reads 0xFFFF; write to 0x104 with evt_i=1 in the same cycle -> next read returns 0x0000 or 0x0001 depending on evt_i in the following cycles, never 0xFFFF.
REQ-036 With WAIT_CYC=3, drop stb_i 2 cycles into WAIT during a write of 0x1234 to 0x101 -> no ack, SCRATCH stays 0xA5A5; with the strobe held, ack arrives at cycle 4.
REQ-037 Assert rst_i=0 during WAIT -> ack_o stays 0, all registers return to reset values.
